// File: rtl/countdown_pkg.sv
// countdown_pkg: shared state type and segment constants for countdown_ctrl
package countdown_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} cd_state_t;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
endpackage

// File: rtl/countdown_ctrl_hex_to_7seg.sv
// hex_to_7seg: hex nibble to active-low {g..a} seven-segment pattern
module hex_to_7seg (
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    always_comb begin
        case (hex)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    end
endmodule

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: preset down-counter with pause/resume, done flag and hex display
// Define COUNTDOWN_BLINK_EN to blink the display while in DONE.
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int N   = 6,
    parameter int DIV = 50_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         start,
    input  logic         pause,
    input  logic [N-1:0] num,
    output logic [N-1:0] count,
    output logic [6:0]   seg1,
    output logic [6:0]   seg2,
    output logic         busy,
    output logic         done
);
    localparam int PW = $clog2(DIV);
    cd_state_t state_q, state_d;
    logic [N-1:0] count_q, count_d;
    logic [PW-1:0] pre_q, pre_d;
    logic wrap, tick;
    logic [6:0] lo_seg, hi_seg;
    assign wrap = pre_q == PW'(DIV - 1);
    assign tick = state_q == RUN && wrap;
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pre_d   = pre_q;
        case (state_q)
            IDLE: begin
                if (load) count_d = num;
                else if (start && count_q != '0) begin
                    state_d = RUN;
                    pre_d   = '0;
                end
            end
            RUN: begin
                if (load) begin
                    count_d = num;
                    pre_d   = '0;
                    state_d = num == '0 ? DONE : RUN;
                end else if (!pause) begin
                    pre_d = tick ? '0 : pre_q + 1'b1;
                    if (tick) begin
                        count_d = count_q - 1'b1;
                        state_d = count_q == N'(1) ? DONE : RUN;
                    end
                end else state_d = PAUSE;
            end
            PAUSE: begin
                if (load) begin
                    count_d = num;
                    state_d = IDLE;
                end else if (start) state_d = RUN;
            end
            DONE: begin
                // prescaler keeps running here so the blink option has a time base
                pre_d = wrap ? '0 : pre_q + 1'b1;
                if (load) begin
                    count_d = num;
                    state_d = IDLE;
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            pre_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pre_q   <= pre_d;
        end
    end
    hex_to_7seg u_lo (.hex(count_q[3:0]), .seg(lo_seg));
    hex_to_7seg u_hi (.hex(4'(count_q[N-1:4])), .seg(hi_seg));
`ifdef COUNTDOWN_BLINK_EN
    logic blink_q, blink_d;
    assign blink_d = (state_q == DONE && state_d == DONE) ? blink_q ^ wrap : 1'b0;
    always_ff @(posedge clk) begin
        if (rst) blink_q <= 1'b0;
        else blink_q <= blink_d;
    end
    assign seg1 = blink_q ? SEG_BLANK : lo_seg;
    assign seg2 = blink_q ? SEG_BLANK : hi_seg;
`else
    assign seg1 = lo_seg;
    assign seg2 = hi_seg;
`endif
    assign count = count_q;
    assign busy  = state_q == RUN;
    assign done  = state_q == DONE;
endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl: directed and randomized checks of countdown_ctrl against a behavioural model
module tb_countdown_ctrl;
    localparam int N = 6;
    localparam int DIV = 4;
    logic clk = 1'b0;
    logic rst = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [N-1:0] num = '0;
    logic [N-1:0] count;
    logic [6:0] seg1, seg2;
    logic busy, done;
    int checks = 0, passed = 0;
    int m_state = 0, m_count = 0, m_pre = 0, m_blink = 0;
    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    countdown_ctrl #(.N(N), .DIV(DIV)) dut (
        .clk(clk), .rst(rst), .load(load), .start(start), .pause(pause), .num(num),
        .count(count), .seg1(seg1), .seg2(seg2), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // states: 0 idle, 1 running, 2 paused, 3 finished; m_pre counts cycles toward the next tick
    task automatic model(input bit r, input bit l, input bit s, input bit p, input int n);
        int old_state, next_blink;
        bit period_end;
        old_state  = m_state;
        period_end = m_pre == DIV - 1;
        if (r) begin
            m_state = 0; m_count = 0; m_pre = 0;
        end else if (m_state == 0) begin
            if (l) m_count = n;
            else if (s && m_count != 0) begin m_state = 1; m_pre = 0; end
        end else if (m_state == 1) begin
            if (l) begin m_count = n; m_pre = 0; m_state = (n == 0) ? 3 : 1; end
            else if (p) m_state = 2;
            else begin
                m_pre = (m_pre + 1) % DIV;
                if (period_end) begin
                    m_count = m_count - 1;
                    if (m_count == 0) m_state = 3;
                end
            end
        end else if (m_state == 2) begin
            if (l) begin m_count = n; m_state = 0; end
            else if (s) m_state = 1;
        end else begin
            m_pre = (m_pre + 1) % DIV;
            if (l) begin m_count = n; m_state = 0; end
        end
        next_blink = (!r && old_state == 3 && m_state == 3) ? (m_blink ^ int'(period_end)) : 0;
`ifdef COUNTDOWN_BLINK_EN
        m_blink = next_blink;
`else
        m_blink = next_blink & 0;
`endif
    endtask

    task automatic cycle(input bit r, input bit l, input bit s, input bit p, input logic [N-1:0] n);
        logic [6:0] e1, e2;
        rst = r; load = l; start = s; pause = p; num = n;
        @(posedge clk);
        model(r, l, s, p, int'(n));
        #1;
        e1 = m_blink != 0 ? 7'h7F : hex_tab[m_count % 16];
        e2 = m_blink != 0 ? 7'h7F : hex_tab[m_count / 16];
        check("count", int'(count), m_count);
        check("busy", int'(busy), int'(m_state == 1));
        check("done", int'(done), int'(m_state == 3));
        check("seg1", int'(seg1), int'(e1));
        check("seg2", int'(seg2), int'(e2));
        rst = 0; load = 0; start = 0; pause = 0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(0, 0, 0, 0, '0);
    endtask

    initial begin
        cycle(1, 0, 0, 0, '0);
        cycle(1, 0, 0, 0, '0);
        check("rst_count", int'(count), 0);
        check("rst_seg1", int'(seg1), 7'b1000000);
        check("rst_seg2", int'(seg2), 7'b1000000);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);

        cycle(0, 1, 0, 0, 6'h12);
        cycle(0, 0, 1, 0, '0);
        check("t2_busy", int'(busy), 1);
        idle(3);
        check("t2_hold", int'(count), 'h12);
        idle(1);
        check("t2_dec1", int'(count), 'h11);
        check("t2_seg2", int'(seg2), 7'b1111001);
        check("t2_seg1", int'(seg1), 7'b1111001);
        idle(4);
        check("t2_dec2", int'(count), 'h10);
        check("t2_seg1b", int'(seg1), 7'b1000000);

        cycle(0, 1, 0, 0, 6'd3);
        cycle(0, 0, 1, 0, '0);
        idle(5);
        cycle(0, 0, 0, 1, '0);
        idle(20);
        check("t3_held", int'(count), 2);
        cycle(0, 0, 1, 0, '0);
        idle(3);
        check("t3_resume", int'(count), 1);
        idle(4);
        check("t3_done", int'(done), 1);
        check("t3_busy", int'(busy), 0);
        idle(40);
        check("t3_stay0", int'(count), 0);

        cycle(0, 1, 0, 0, 6'd9);
        cycle(0, 0, 1, 0, '0);
        cycle(0, 1, 0, 0, 6'd0);
        check("t4_zero", int'(count), 0);
        check("t4_done", int'(done), 1);
        cycle(0, 1, 0, 0, 6'd5);
        check("t4_idle_done", int'(done), 0);
        check("t4_count", int'(count), 5);

        cycle(0, 0, 1, 0, '0);
        idle(3);
        cycle(0, 0, 0, 1, '0);
        check("t5_pause_tick", int'(count), 5);
        cycle(1, 0, 0, 0, '0);
        cycle(0, 0, 1, 0, '0);
        check("t5_start0", int'(busy), 0);
        cycle(0, 1, 0, 0, 6'd7);
        cycle(0, 0, 1, 0, '0);
        idle(2);
        cycle(1, 0, 0, 0, '0);
        check("t5_rst_run", int'(count), 0);
        check("t5_rst_busy", int'(busy), 0);

        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] n;
            n = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 63)) : N'($urandom_range(0, 5));
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 6,
                  $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 6, n);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
